i2c_reg_bank: RTL and testbench
===============================

Name: i2c_reg_bank

Overview:
- System-clock register map sitting directly downstream of the I2C slave; it consumes the slave's write strobe, register address and write data.
- It returns read data to the slave's `reg_data_in`.
- Performs CDC from the SCL domain into `clk`. Holds ID, control, status/sticky-event and general configuration registers that drive the controller core.

Parameters:
- NUM_CFG, 4, number of general RW config registers at addresses 0x03..0x03+NUM_CFG-1 (1..252).
- SYNC_STAGES, 2, flop depth of every SCL-to-clk synchronizer (>=2).
- ID_VALUE, 8'hA5, constant returned at address 0x00.

Ports:
- clk  in  1  system clock; must run at >=4x SCL frequency.
- rstn  in  1  asynchronous active-low reset.
- wr_strobe_async  in  1  write strobe from I2C slave (`reg_write`); high for one SCL period.
- addr_async  in  8  register address from slave (`reg_data_addr`); quasi-static.
- wdata_async  in  8  write data from slave (`reg_data_out`); stable while strobe high.
- rd_data  out  8  read data to slave (`reg_data_in`), registered.
- status_in  in  4  live status bits, already synchronous to clk.
- event_in  in  4  single-cycle event pulses, synchronous to clk.
- enable  out  1  CTRL[0].
- soft_rst  out  1  one-cycle pulse on write of CTRL[1]=1.
- cfg_out  out  8*NUM_CFG  config registers; reg i occupies bits [8i+7:8i].

Behaviour:
- Reset values (asynchronous, while rstn low):
  - `rd_data`=0, `enable`=0, `soft_rst`=0, `cfg_out`=0.
  - Sticky bits=0, all synchronizer flops=0.
- Register map:
  - 0x00 ID: RO, ID_VALUE; writes ignored.
  - 0x01 CTRL: bit0 RW enable; bit1 write-only, reads 0; bits[7:2] read 0, writes ignored.
  - 0x02 STATUS:
    - Read = {sticky[3:0], status_in[3:0]}.
    - Write: bits[7:4] are W1C; bits[3:0] ignored.
  - 0x03..0x03+NUM_CFG-1: RW config.
  - All other addresses read 0x00; writes are dropped without side effects.
- Write path:
  - `wr_strobe_async` passes through SYNC_STAGES flops, then a rising-edge detector, producing internal `wr_pulse` (one clk).
  - On `wr_pulse`, `addr_async` and `wdata_async` are sampled directly; they are stable for >=1 SCL period before and during the strobe by slave construction.
  - Target register updates at the clk edge after `wr_pulse`. The new value is visible on outputs SYNC_STAGES+1 clk edges after the strobe is first sampled high.
  - A strobe held high for many clk cycles produces exactly one write.
  - Strobe low time between writes is >=8 SCL periods, so no back-to-back merging needs handling.
- Sticky events:
  - `event_in[i]`=1 sets `sticky[i]`.
  - W1C with `wdata[4+i]`=1 clears it.
  - Set and clear in the same cycle: set wins, bit stays 1.
- soft_rst:
  - High exactly the one clk cycle following a write to 0x01 with bit1=1, independent of bit0.
  - Does not reset the bank itself.
- Read path:
  - `addr_async` passes through SYNC_STAGES flops.
  - A filter register `rd_addr_q` loads the synchronized value only when the last two synchronized samples are equal. Mid-transition skew therefore never selects a wrong register.
  - `rd_data` is registered each clk from the mux at `rd_addr_q`. It reflects register changes one clk after they occur.
  - Worst-case latency from an `addr_async` change to `rd_data` valid: SYNC_STAGES+2 clk cycles.
- Reset mid-operation: rstn low at any time clears everything asynchronously. A strobe still high when rstn rises causes no write until it falls and rises again, because the edge detector resets with history 0 and requires 0->1 seen after reset.
- No internal state machine beyond synchronizers, edge detector, filter and registers. All logic is on `posedge clk`/`negedge rstn`.

Optional Feature:
- Macro: REG_BANK_WRCNT_EN.
- Defined:
  - Adds RO register at 0xFF counting accepted writes to mapped addresses, saturating at 8'hFF.
  - Dropped writes (unmapped or ID) are not counted.
  - Cleared by rstn or by any write to 0xFF (the clearing write is not counted).
- Undefined: 0xFF is unmapped (reads 0x00) and no counter logic exists.

Test Plan:
- Reset release, `addr_async`=0x00 held -> `rd_data`=0xA5 within SYNC_STAGES+2 clks; `enable`=0, `cfg_out`=0.
- Strobe with addr 0x03, data 0x5C, high for 40 clks -> `cfg_out[7:0]`=0x5C after exactly 3 clks (SYNC_STAGES=2); only one write occurs; `addr_async`=0x03 then reads back 0x5C.
- Write 0x01 with data 0x03 -> `enable`=1; `soft_rst` high for exactly 1 clk; readback of 0x01 = 0x01.
- `event_in`=4'b0101 pulse, then `status_in`=4'hA -> read 0x02 = 0x5A.
- W1C: write 0x02 with 0x10 in the same cycle as `event_in[0]` pulses -> bit4 remains 1. Write 0x02 with 0x50 with no event -> read 0x02 = 0x0A.
- Write to 0x00 and 0x80 -> no output change, reads 0xA5/0x00.
- With REG_BANK_WRCNT_EN: 3 mapped writes plus 1 unmapped write -> 0xFF reads 0x03. A write to 0xFF -> reads 0x00.

Source files
------------

// File: rtl/i2c_reg_bank_if.sv
// Register-access bus between the I2C slave (SCL domain) and the clk-domain register bank.
interface i2c_reg_bank_if;
    logic       wr_strobe_async;
    logic [7:0] addr_async;
    logic [7:0] wdata_async;
    logic [7:0] rd_data;

    modport master (output wr_strobe_async, output addr_async, output wdata_async, input rd_data);
    modport slave  (input wr_strobe_async, input addr_async, input wdata_async, output rd_data);
endinterface

// File: rtl/i2c_reg_bank.sv
// clk-domain register map behind the I2C slave: ID, CTRL, STATUS/sticky and NUM_CFG config registers.
// Define REG_BANK_WRCNT_EN to add a saturating accepted-write counter at 0xFF.
module i2c_reg_bank #(
    parameter int unsigned NUM_CFG     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rstn,
    i2c_reg_bank_if.slave        bus,
    input  logic [3:0]           status_in,
    input  logic [3:0]           event_in,
    output logic                 enable,
    output logic                 soft_rst,
    output logic [8*NUM_CFG-1:0] cfg_out
);

    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] wr_vld;
    logic                   wr_prev;
    logic                   wr_armed;
    logic                   wr_pulse;
    logic [7:0]             addr_sync [SYNC_STAGES];
    logic [7:0]             rd_addr_q;
    logic [3:0]             sticky;
    logic [7:0]             rd_mux;
    logic                   wr_ctrl;
    logic                   wr_stat;
    logic [NUM_CFG-1:0]     wr_cfg;

    // wr_vld tracks which sync flops hold real samples; the detector arms only after a genuine
    // low is seen, so a strobe still high across reset release cannot cause a write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_sync  <= '0;
            wr_vld   <= '0;
            wr_prev  <= 1'b0;
            wr_armed <= 1'b0;
        end else begin
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], bus.wr_strobe_async};
            wr_vld   <= {wr_vld[SYNC_STAGES-2:0], 1'b1};
            wr_prev  <= wr_sync[SYNC_STAGES-1];
            wr_armed <= wr_armed | (wr_vld[SYNC_STAGES-1] & ~wr_sync[SYNC_STAGES-1]);
        end
    end

    assign wr_pulse = wr_armed & wr_sync[SYNC_STAGES-1] & ~wr_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) addr_sync[i] <= '0;
            rd_addr_q <= '0;
        end else begin
            addr_sync[0] <= bus.addr_async;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) addr_sync[i] <= addr_sync[i-1];
            // Only accept an address once two consecutive samples agree.
            if (addr_sync[SYNC_STAGES-1] == addr_sync[SYNC_STAGES-2])
                rd_addr_q <= addr_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        wr_ctrl = wr_pulse && (bus.addr_async == 8'h01);
        wr_stat = wr_pulse && (bus.addr_async == 8'h02);
        wr_cfg  = '0;
        for (int unsigned i = 0; i < NUM_CFG; i++)
            wr_cfg[i] = wr_pulse && (bus.addr_async == 8'(3 + i));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            enable   <= 1'b0;
            soft_rst <= 1'b0;
            sticky   <= '0;
            cfg_out  <= '0;
        end else begin
            soft_rst <= wr_ctrl & bus.wdata_async[1];
            if (wr_ctrl) enable <= bus.wdata_async[0];
            // Event set has priority over a simultaneous W1C.
            sticky <= (sticky & ~(wr_stat ? bus.wdata_async[7:4] : 4'h0)) | event_in;
            for (int unsigned i = 0; i < NUM_CFG; i++)
                if (wr_cfg[i]) cfg_out[8*i +: 8] <= bus.wdata_async;
        end
    end

`ifdef REG_BANK_WRCNT_EN
    logic       wr_mapped;
    logic [7:0] wr_cnt;

    assign wr_mapped = wr_ctrl | wr_stat | (|wr_cfg);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wr_cnt <= '0;
        else if (wr_pulse && (bus.addr_async == 8'hFF))
            wr_cnt <= '0;
        else if (wr_mapped && (wr_cnt != 8'hFF))
            wr_cnt <= wr_cnt + 8'd1;
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (rd_addr_q)
            8'h00: rd_mux = ID_VALUE;
            8'h01: rd_mux = {7'b0, enable};
            8'h02: rd_mux = {sticky, status_in};
`ifdef REG_BANK_WRCNT_EN
            8'hFF: rd_mux = wr_cnt;
`endif
            default: begin
                for (int unsigned i = 0; i < NUM_CFG; i++)
                    if (rd_addr_q == 8'(3 + i)) rd_mux = cfg_out[8*i +: 8];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) bus.rd_data <= '0;
        else       bus.rd_data <= rd_mux;
    end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench for i2c_reg_bank: stimulus queues timed expectations from a register-map model,
// a negedge monitor compares them against the DUT.
module tb_i2c_reg_bank;
  localparam int unsigned NUM_CFG = 4;
  localparam int unsigned SS      = 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [3:0]           status_in = 4'h0;
  logic [3:0]           event_in = 4'h0;
  logic                 enable;
  logic                 soft_rst;
  logic [8*NUM_CFG-1:0] cfg_out;

  i2c_reg_bank_if bus();

  i2c_reg_bank #(.NUM_CFG(NUM_CFG), .SYNC_STAGES(SS), .ID_VALUE(8'hA5)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .status_in(status_in), .event_in(event_in),
    .enable(enable), .soft_rst(soft_rst), .cfg_out(cfg_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    int unsigned kind;   // 0 rd_data, 1 enable, 2 soft_rst, 3 cfg_out
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model of the register map
  logic [7:0] m_cfg [NUM_CFG];
  logic       m_en;
  logic [3:0] m_sticky;
  logic [7:0] m_cnt;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a == 8'h00) return 8'hA5;
    if (a == 8'h01) return {7'b0, m_en};
    if (a == 8'h02) return {m_sticky, status_in};
    if (a >= 8'h03 && int'(a) < 3 + NUM_CFG) return m_cfg[a - 8'h03];
`ifdef REG_BANK_WRCNT_EN
    if (a == 8'hFF) return m_cnt;
`endif
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_cfg_flat();
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < int'(NUM_CFG); i++) f[8*i +: 8] = m_cfg[i];
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(NUM_CFG); i++) m_cfg[i] = 8'h00;
    m_en = 1'b0; m_sticky = 4'h0; m_cnt = 8'h00;
  endtask

  task automatic expect_at(input int unsigned due, input int unsigned kind,
                           input logic [31:0] exp, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int unsigned kind);
    case (kind)
      0: return {24'b0, bus.rd_data};
      1: return {31'b0, enable};
      2: return {31'b0, soft_rst};
      default: return 32'(cfg_out);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [31:0] act;
        act = actual(sb[i].kind);
        n_cmp++;
        if (sb[i].due < cyc || act !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s: got %h want %h (cycle %0d, due %0d)",
                   sb[i].name, act, sb[i].exp, cyc, sb[i].due);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe first sampled at edge c+1; target updates at edge c+SS+1.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          input int unsigned hold, input logic [3:0] ev);
    int unsigned c;
    logic [31:0] old_cfg;
    logic        old_en;
    logic        mapped;
    bus.addr_async = a; bus.wdata_async = d;
    tick(2);
    c = cyc;
    old_cfg = m_cfg_flat(); old_en = m_en;
    mapped = 1'b0;
    if (a == 8'h01) begin m_en = d[0]; mapped = 1'b1; end
    if (a == 8'h02) mapped = 1'b1;
    if (a >= 8'h03 && int'(a) < 3 + NUM_CFG) begin m_cfg[a - 8'h03] = d; mapped = 1'b1; end
    m_sticky = (m_sticky & ~((a == 8'h02) ? d[7:4] : 4'h0)) | ev;
    if (a == 8'hFF) m_cnt = 8'h00;
    else if (mapped && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    expect_at(c + SS,     3, old_cfg,      "cfg_before");
    expect_at(c + SS + 1, 3, m_cfg_flat(), "cfg_after");
    expect_at(c + SS,     1, {31'b0, old_en}, "en_before");
    expect_at(c + SS + 1, 1, {31'b0, m_en},   "en_after");
    expect_at(c + SS,     2, 32'd0, "softrst_before");
    expect_at(c + SS + 1, 2, {31'b0, (a == 8'h01) && d[1]}, "softrst_pulse");
    expect_at(c + SS + 2, 2, 32'd0, "softrst_after");
    expect_at(c + SS + 3, 3, m_cfg_flat(), "cfg_single_write");
    bus.wr_strobe_async = 1'b1;
    tick(SS);
    event_in = ev;
    tick(1);
    event_in = 4'h0;
    tick(hold - SS - 1);
    bus.wr_strobe_async = 1'b0;
    tick(12);
  endtask

  task automatic check_read(input logic [7:0] a, input string name);
    bus.addr_async = a;
    expect_at(cyc + SS + 2, 0, {24'b0, m_read(a)}, name);
    tick(SS + 4);
  endtask

  task automatic pulse_event(input logic [3:0] ev);
    event_in = ev;
    tick(1);
    event_in = 4'h0;
    m_sticky = m_sticky | ev;
    tick(1);
  endtask

  logic [7:0] pick [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                            8'h07, 8'h80, 8'hFF, 8'h00};

  initial begin
    bus.wr_strobe_async = 1'b0; bus.addr_async = 8'h00; bus.wdata_async = 8'h00;
    m_reset();
    tick(2);
    n_cmp++;
    if (bus.rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL direct_reset_rd_data: got %h", bus.rd_data);
    end
    n_cmp++;
    if (enable !== 1'b0) begin
      n_err++;
      $display("FAIL direct_reset_enable: got %b", enable);
    end
    n_cmp++;
    if (soft_rst !== 1'b0) begin
      n_err++;
      $display("FAIL direct_reset_soft_rst: got %b", soft_rst);
    end
    n_cmp++;
    if (cfg_out !== '0) begin
      n_err++;
      $display("FAIL direct_reset_cfg: got %h", cfg_out);
    end
    expect_at(cyc + 1, 0, 32'd0, "reset_rd_data");
    expect_at(cyc + 1, 1, 32'd0, "reset_enable");
    expect_at(cyc + 1, 2, 32'd0, "reset_soft_rst");
    expect_at(cyc + 1, 3, 32'd0, "reset_cfg");
    tick(2);
    rstn = 1'b1;
    expect_at(cyc + SS + 2, 0, 32'h0000_00A5, "id_after_reset");
    tick(8);

    do_write(8'h03, 8'h5C, 40, 4'h0);
    check_read(8'h03, "read_cfg0");
    do_write(8'h01, 8'h03, 6, 4'h0);
    check_read(8'h01, "read_ctrl");
    pulse_event(4'b0101);
    status_in = 4'hA;
    check_read(8'h02, "read_status_events");
    do_write(8'h02, 8'h10, 6, 4'b0001);
    check_read(8'h02, "w1c_set_wins");
    do_write(8'h02, 8'h50, 6, 4'h0);
    check_read(8'h02, "w1c_clear");
    do_write(8'h00, 8'h3C, 6, 4'h0);
    do_write(8'h80, 8'h77, 6, 4'h0);
    check_read(8'h00, "read_id_after_write");
    check_read(8'h80, "read_unmapped");

    do_write(8'hFF, 8'h00, 6, 4'h0);
    do_write(8'h04, 8'h11, 6, 4'h0);
    do_write(8'h05, 8'h22, 6, 4'h0);
    do_write(8'h01, 8'h01, 6, 4'h0);
    do_write(8'h90, 8'h33, 6, 4'h0);
    check_read(8'hFF, "wrcnt_three");
    do_write(8'hFF, 8'h00, 6, 4'h0);
    check_read(8'hFF, "wrcnt_cleared");

    for (int n = 0; n < 40; n++) begin
      logic [7:0] a;
      a = pick[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) a = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 1: do_write(a, 8'($urandom), $urandom_range(4, 20), 4'($urandom));
        2: check_read(a, "rand_read");
        default: begin
          pulse_event(4'($urandom));
          status_in = 4'($urandom);
          check_read(8'h02, "rand_status");
        end
      endcase
    end

    // Reset while strobe is high: no write may occur until the strobe toggles again.
    bus.addr_async = 8'h04; bus.wdata_async = 8'hC3; bus.wr_strobe_async = 1'b1;
    tick(3);
    rstn = 1'b0;
    m_reset();
    expect_at(cyc + 1, 3, 32'd0, "cfg_cleared_by_reset");
    expect_at(cyc + 1, 1, 32'd0, "enable_cleared_by_reset");
    tick(3);
    rstn = 1'b1;
    expect_at(cyc + SS + 2, 3, 32'd0, "no_write_after_reset_a");
    expect_at(cyc + 15,     3, 32'd0, "no_write_after_reset_b");
    tick(16);
    bus.wr_strobe_async = 1'b0;
    tick(12);
    do_write(8'h04, 8'h3C, 8, 4'h0);
    check_read(8'h04, "write_after_rearm");
    n_cmp++;
    if (cfg_out[15:8] !== 8'h3C) begin
      n_err++;
      $display("FAIL direct_cfg1_after_rearm: got %h", cfg_out[15:8]);
    end

    tick(10);
    while (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: never checked (due %0d, now %0d)", sb[0].name, sb[0].due, cyc);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
